// File: rtl/store_merge_unit.sv
// store_merge_unit
// Writes SB/SH/SW requests into a word-only data memory. A sub-word store
// reads the target word and merges the new byte or halfword into it, then
// writes the word back. A word store writes directly without a read.
// Misaligned and reserved-size requests are rejected without any memory access.
module store_merge_unit (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic        start,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        misalign,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WR   = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  logic [2:0]  state_q,  state_d;
  logic [31:0] addr_q,   addr_d;
  logic [1:0]  size_q,   size_d;
  logic [15:0] wdata_q,  wdata_d;   // only the low halfword is needed for SB/SH
  logic [31:0] merged_q, merged_d;

  // Returns 1 when the request cannot be issued to a word-only memory.
  function automatic logic is_reject(input logic [1:0] sz, input logic [1:0] a_lo);
    logic rej;
    rej = 1'b0;
    case (sz)
      SZ_H:    rej = a_lo[0];
      SZ_W:    rej = (a_lo != 2'b00);
      SZ_B:    rej = 1'b0;
      default: rej = 1'b1;
    endcase
    return rej;
  endfunction

  // Places the new byte/halfword into its lane; other lanes keep the old word.
  function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                             input logic [15:0] new_d,
                                             input logic [1:0]  sz,
                                             input logic [1:0]  a_lo);
    logic [31:0] w;
    w = old_w;
    if (sz == SZ_B) begin
      case (a_lo)
        2'd0:    w[7:0]   = new_d[7:0];
        2'd1:    w[15:8]  = new_d[7:0];
        2'd2:    w[23:16] = new_d[7:0];
        default: w[31:24] = new_d[7:0];
      endcase
    end else if (sz == SZ_H) begin
      if (a_lo[1]) w[31:16] = new_d;
      else         w[15:0]  = new_d;
    end
    return w;
  endfunction

  // Next-state and datapath register update.
  always_comb begin
    // NOTE: every _d signal gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    wdata_d  = wdata_q;
    merged_d = merged_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = addr;
          size_d  = size;
          wdata_d = wdata[15:0];
          if (is_reject(size, addr[1:0])) begin
            state_d = S_ERR;
          end else if (size == SZ_W) begin
            state_d  = S_WR;
            merged_d = wdata;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (mem_ready) begin
          merged_d = merge_word(mem_rdata, wdata_q, size_q, addr_q[1:0]);
          state_d  = S_WR;
        end
      end
      S_WR: begin
        if (mem_ready) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      // NOTE: the data-holding registers clear too, so no stale store data survives a reset.
      state_q  <= S_IDLE;
      addr_q   <= '0;
      size_q   <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples the pre-edge values together.
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      wdata_q  <= wdata_d;
      merged_q <= merged_d;
    end
  end

  // Outputs decode only from registers. Reset forces them low asynchronously.
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE) || (state_q == S_ERR);
  assign misalign  = (state_q == S_ERR);
  assign mem_re    = (state_q == S_RD);
  assign mem_we    = (state_q == S_WR);
  assign mem_addr  = (mem_re || mem_we) ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_wdata = mem_we ? merged_q : 32'h0;

endmodule

// File: tb/tb_store_merge_unit.sv
// tb_store_merge_unit
// Directed stimulus pushes expected writes and completions into queues.
// A negedge monitor pops and compares them when the DUT writes or signals done.
module tb_store_merge_unit;

  logic        CLK;
  logic        RST_n;
  logic        start;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        misalign;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_exp_t;

  typedef struct {
    logic mis;
    int   cyc;
    int   reads;
    int   writes;
  } done_exp_t;

  wr_exp_t   wr_q[$];
  done_exp_t done_q[$];

  // Memory model
  logic [31:0] mem [4];
  int          stall_cnt = 0;
  int          rd_wait   = 0;
  int          wr_wait   = 0;
  logic        pre_en    = 1'b0;
  logic [31:0] pre_data  = 32'h0;

  store_merge_unit dut (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .start     (start),
    .size      (size),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .misalign  (misalign),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  assign mem_rdata = mem[mem_addr[3:2]];
  assign mem_ready = (mem_re && (stall_cnt >= rd_wait)) || (mem_we && (stall_cnt >= wr_wait));

  // Memory: counts wait states per access and commits accepted writes.
  always @(posedge CLK) begin
    if ((mem_re || mem_we) && !mem_ready) stall_cnt <= stall_cnt + 1;
    else                                  stall_cnt <= 0;
    if (pre_en)                           mem[0] <= pre_data;
    else if (mem_we && mem_ready)         mem[mem_addr[3:2]] <= mem_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic report_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  // Monitor: pops and compares whenever the DUT writes or completes.
  int        rd_cnt = 0;
  int        wr_cnt = 0;
  wr_exp_t   mon_w;
  done_exp_t mon_d;
  always @(negedge CLK) begin
    if (!RST_n) begin
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      check("re_we_exclusive", 32'(mem_re & mem_we), 32'h0);
      if (mem_re && mem_ready) rd_cnt++;
      if (mem_we && mem_ready) begin
        wr_cnt++;
        if (wr_q.size() == 0) report_fail("unexpected_write");
        else begin
          mon_w = wr_q.pop_front();
          check("wr_addr", mem_addr, mon_w.addr);
          check("wr_data", mem_wdata, mon_w.data);
        end
      end
      if (done) begin
        if (done_q.size() == 0) report_fail("unexpected_done");
        else begin
          mon_d = done_q.pop_front();
          check("misalign", 32'(misalign), 32'(mon_d.mis));
          check("done_cycle", 32'(cyc), 32'(mon_d.cyc));
          check("read_count", 32'(rd_cnt), 32'(mon_d.reads));
          check("write_count", 32'(wr_cnt), 32'(mon_d.writes));
          check("busy_at_done", 32'(busy), 32'h1);
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
    end
  end

  task automatic preload(input logic [31:0] v);
    @(negedge CLK);
    pre_data = v;
    pre_en   = 1'b1;
    @(negedge CLK);
    pre_en   = 1'b0;
  endtask

  // Issues one request and queues its expected write and completion.
  task automatic do_req(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                        input logic exp_mis, input int lat, input int reads,
                        input logic [31:0] exp_data, input bit pulse_busy);
    done_exp_t d;
    wr_exp_t   w;
    bit        seen;
    @(negedge CLK);
    d.mis    = exp_mis;
    d.cyc    = cyc + lat;
    d.reads  = reads;
    d.writes = exp_mis ? 0 : 1;
    done_q.push_back(d);
    if (!exp_mis) begin
      w.addr = {a[31:2], 2'b00};
      w.data = exp_data;
      wr_q.push_back(w);
    end
    start = 1'b1;
    size  = sz;
    addr  = a;
    wdata = wd;
    @(negedge CLK);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'h1);
    if (pulse_busy) begin
      start = 1'b1;
      size  = 2'b10;
      addr  = 32'h104;
      wdata = 32'h11111111;
      @(negedge CLK);
      start = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) seen = 1'b1;
      else @(negedge CLK);
    end
    check("done_seen", 32'(seen), 32'h1);
    @(negedge CLK);
    check("idle_busy", 32'(busy), 32'h0);
    check("idle_done", 32'(done), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_n = 1'b0;
    start = 1'b0;
    size  = 2'b00;
    addr  = 32'h0;
    wdata = 32'h0;
    #3;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_misalign", 32'(misalign), 32'h0);
    check("rst_mem_re", 32'(mem_re), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    RST_n = 1'b1;

    // Byte stores into each lane
    preload(32'hABCDEF17);
    do_req(2'b00, 32'h101, 32'h00000055, 1'b0, 3, 1, 32'hABCD5517, 1'b0);
    preload(32'hABCDEF17);
    do_req(2'b00, 32'h100, 32'h00000055, 1'b0, 3, 1, 32'hABCDEF55, 1'b0);
    preload(32'hABCDEF17);
    do_req(2'b00, 32'h102, 32'h00000055, 1'b0, 3, 1, 32'hAB55EF17, 1'b0);
    preload(32'hABCDEF17);
    do_req(2'b00, 32'h103, 32'h00000055, 1'b0, 3, 1, 32'h55CDEF17, 1'b0);
    preload(32'hABCDEF17);
    do_req(2'b00, 32'h103, 32'h12345699, 1'b0, 3, 1, 32'h99CDEF17, 1'b0);

    // Halfword stores, upper and lower half
    preload(32'hABCDEF17);
    do_req(2'b01, 32'h102, 32'h00001234, 1'b0, 3, 1, 32'h1234EF17, 1'b0);
    preload(32'hABCDEF17);
    do_req(2'b01, 32'h100, 32'hBEEF1234, 1'b0, 3, 1, 32'hABCD1234, 1'b0);

    // Word store bypasses the read
    do_req(2'b10, 32'h100, 32'hDEADBEEF, 1'b0, 2, 0, 32'hDEADBEEF, 1'b0);

    // Rejected requests
    do_req(2'b01, 32'h103, 32'h00001234, 1'b1, 1, 0, 32'h0, 1'b0);
    do_req(2'b10, 32'h102, 32'hDEADBEEF, 1'b1, 1, 0, 32'h0, 1'b0);
    do_req(2'b11, 32'h100, 32'hDEADBEEF, 1'b1, 1, 0, 32'h0, 1'b0);

    // Wait states in RD and WR, with a start pulse ignored while busy
    preload(32'hABCDEF17);
    rd_wait = 3;
    wr_wait = 2;
    do_req(2'b00, 32'h101, 32'h00000055, 1'b0, 8, 1, 32'hABCD5517, 1'b1);
    rd_wait = 0;
    wr_wait = 0;
    repeat (4) @(negedge CLK);
    check("queues_empty", 32'(wr_q.size() + done_q.size()), 32'h0);

    // Reset during WR drops the write immediately
    preload(32'hABCDEF17);
    wr_wait = 20;
    @(negedge CLK);
    start = 1'b1;
    size  = 2'b10;
    addr  = 32'h100;
    wdata = 32'hCAFEF00D;
    @(negedge CLK);
    start = 1'b0;
    check("abort_we_before", 32'(mem_we), 32'h1);
    #2;
    RST_n = 1'b0;
    #1;
    check("abort_mem_we", 32'(mem_we), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    check("abort_mem_addr", mem_addr, 32'h0);
    check("abort_mem_wdata", mem_wdata, 32'h0);
    @(negedge CLK);
    RST_n   = 1'b1;
    wr_wait = 0;
    check("post_rst_busy", 32'(busy), 32'h0);
    @(negedge CLK);
    check("mem_unchanged", mem[0], 32'hABCDEF17);
    do_req(2'b10, 32'h100, 32'h0BADF00D, 1'b0, 2, 0, 32'h0BADF00D, 1'b0);
    repeat (3) @(negedge CLK);
    check("final_queues_empty", 32'(wr_q.size() + done_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
